// File: rtl/bcd_to_binary_pkg.sv
// ----------------------------------------------------------------------------
// bcd_to_binary_pkg
// Shared definitions for the packed-BCD to binary converter:
//   - state_t       : converter FSM states (IDLE, CONV, DONE)
//   - BCD_DIGIT_W   : width of one BCD digit
//   - BCD_MAX_DIGIT : largest legal decimal digit
//   - digit_invalid : flags a 4-bit digit outside 0..9
// ----------------------------------------------------------------------------
package bcd_to_binary_pkg;

    localparam int unsigned BCD_DIGIT_W   = 4;
    localparam int unsigned BCD_MAX_DIGIT = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic digit_invalid(input logic [BCD_DIGIT_W-1:0] digit);
        return digit > BCD_DIGIT_W'(BCD_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/bcd_to_binary_if.sv
// ----------------------------------------------------------------------------
// bcd_to_binary_if
// Request/result handshake bundle for bcd_to_binary.
// Parameters: DIGITS (BCD digits per request), OUT_W (result width).
// Signals:
//   in_valid  : requester has a value on bcd_in
//   in_ready  : converter can accept a request
//   bcd_in    : packed BCD, most significant digit in the top nibble
//   out_valid : bin_out holds a result
//   out_ready : consumer accepts the result
//   bin_out   : unsigned binary result
//   err       : (BCD2BIN_DIGIT_CHECK_EN only) a digit > 9 was seen
// Modports: master = requester/consumer side, slave = converter side.
// ----------------------------------------------------------------------------
interface bcd_to_binary_if #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned OUT_W  = 14
);

    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_W-1:0]      bin_out;
`ifdef BCD2BIN_DIGIT_CHECK_EN
    logic                  err;
`endif

    modport master (
        output in_valid,
        output bcd_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
`ifdef BCD2BIN_DIGIT_CHECK_EN
        input  err,
`endif
        input  bin_out
    );

    modport slave (
        input  in_valid,
        input  bcd_in,
        input  out_ready,
        output in_ready,
        output out_valid,
`ifdef BCD2BIN_DIGIT_CHECK_EN
        output err,
`endif
        output bin_out
    );

endinterface

// File: rtl/bcd_to_binary_digit_mac.sv
// ----------------------------------------------------------------------------
// bcd_to_binary_digit_mac
// Combinational Horner step: result = trunc_OUT_W(acc*10 + digit).
// The product is formed as (acc<<3)+(acc<<1) at OUT_W+4 bits and wraps
// modulo 2^OUT_W on truncation (no saturation).
// Ports:
//   acc       : running accumulator
//   digit     : next BCD digit (arithmetic 4-bit value)
//   result    : acc*10 + digit, truncated to OUT_W
//   digit_bad : digit is above 9
// ----------------------------------------------------------------------------
module bcd_to_binary_digit_mac
    import bcd_to_binary_pkg::*;
#(
    parameter int unsigned OUT_W = 14
) (
    input  logic [OUT_W-1:0]       acc,
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [OUT_W-1:0]       result,
    output logic                   digit_bad
);

    logic [OUT_W+3:0] acc_w;
    logic [OUT_W+3:0] sum_w;
    logic             unused_hi;

    assign acc_w     = {4'b0000, acc};
    assign sum_w     = (acc_w << 3) + (acc_w << 1) + {{OUT_W{1'b0}}, digit};
    assign result    = sum_w[OUT_W-1:0];
    // Bits above OUT_W are the wrapped-away part of the product.
    assign unused_hi = ^sum_w[OUT_W+3:OUT_W];
    assign digit_bad = digit_invalid(digit);

endmodule

// File: rtl/bcd_to_binary.sv
// ----------------------------------------------------------------------------
// bcd_to_binary
// Sequential packed-BCD to unsigned binary converter. One digit per clock,
// most significant first (acc = acc*10 + digit); fixed latency of DIGITS
// cycles from accept to out_valid. Valid/ready handshakes on both sides.
// Parameters: DIGITS (1..8), OUT_W (result width, wraps modulo 2^OUT_W).
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : bcd_to_binary_if.slave (in_valid/in_ready/bcd_in,
//           out_valid/out_ready/bin_out[, err])
// Optional feature macro: BCD2BIN_DIGIT_CHECK_EN adds a sticky err output
// flagging digits > 9; bin_out is forced to 0 for such conversions.
// ----------------------------------------------------------------------------
module bcd_to_binary
    import bcd_to_binary_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned OUT_W  = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    bcd_to_binary_if.slave    bus
);

    localparam int unsigned SR_W  = BCD_DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t             state;
    state_t             state_next;
    logic [SR_W-1:0]    shift_reg;
    logic [CNT_W-1:0]   cnt;
    logic [OUT_W-1:0]   acc;
    logic [OUT_W-1:0]   bin_q;
    logic [OUT_W-1:0]   mac_result;
    logic               digit_bad;
    logic               in_ready;
    logic               accept;
    logic               last_digit;

    assign in_ready   = (state == IDLE) && rst_n;
    assign accept     = bus.in_valid && in_ready;
    assign last_digit = (state == CONV) && (cnt == '0);

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state == DONE);
    assign bus.bin_out   = bin_q;

    bcd_to_binary_digit_mac #(
        .OUT_W (OUT_W)
    ) u_mac (
        .acc       (acc),
        .digit     (shift_reg[SR_W-1 -: BCD_DIGIT_W]),
        .result    (mac_result),
        .digit_bad (digit_bad)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept)        state_next = CONV;
            CONV: if (cnt == '0)     state_next = DONE;
            DONE: if (bus.out_ready) state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

`ifdef BCD2BIN_DIGIT_CHECK_EN
    logic err_q;
    logic err_now;

    // Sticky flag including the digit being consumed this cycle.
    assign err_now = err_q || digit_bad;
    assign bus.err = (state == DONE) && err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept)        err_q <= 1'b0;
                CONV:                    err_q <= err_now;
                DONE: if (bus.out_ready) err_q <= 1'b0;
                default:                 err_q <= 1'b0;
            endcase
        end
    end
`else
    logic unused_digit_bad;
    logic err_now;

    assign unused_digit_bad = digit_bad;
    assign err_now          = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // bin_q is loaded on the final CONV edge rather than mirroring acc, so
    // the result survives the return to IDLE and the accumulator clear of
    // the next request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            cnt       <= '0;
            acc       <= '0;
            bin_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shift_reg <= bus.bcd_in;
                        acc       <= '0;
                        cnt       <= CNT_W'(DIGITS - 1);
                    end
                end
                CONV: begin
                    acc       <= mac_result;
                    shift_reg <= shift_reg << BCD_DIGIT_W;
                    cnt       <= cnt - CNT_W'(1);
                    if (last_digit) begin
                        bin_q <= err_now ? '0 : mac_result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_binary.sv
module tb_bcd_to_binary;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_to_binary_if #(.DIGITS(4), .OUT_W(14)) bus ();
    bcd_to_binary_if #(.DIGITS(3), .OUT_W(8))  bus8 ();

    bcd_to_binary #(.DIGITS(4), .OUT_W(14)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    bcd_to_binary #(.DIGITS(3), .OUT_W(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [15:0] bcd;
        int          hold;
        int          exp_val;
        bit          exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: positional decimal value sum(d_i * 10^i), wrapped to outw bits.
    function automatic longint model(input logic [31:0] bcd, input int digits,
                                     input int outw, output bit err);
        longint v = 0;
        longint p = 1;
        logic [3:0] d;
        err = 1'b0;
        for (int i = 0; i < digits; i++) begin
            d = bcd[4*i +: 4];
            if (d > 4'd9) err = 1'b1;
            v = v + longint'(d) * p;
            p = p * 10;
        end
`ifdef BCD2BIN_DIGIT_CHECK_EN
        if (err) v = 0;
`else
        err = 1'b0;
`endif
        return v % (longint'(1) << outw);
    endfunction

    function automatic bit cur_err();
`ifdef BCD2BIN_DIGIT_CHECK_EN
        return bus.err;
`else
        return 1'b0;
`endif
    endfunction

    // One full conversion on the 4-digit DUT. proto_ok collects handshake
    // rules: in_ready low while busy, result stable under backpressure,
    // out_valid drops on handshake with bin_out held.
    task automatic run_conv(input logic [15:0] bcd, input int hold, input bit noise,
                            output longint res, output bit err_o, output int lat,
                            output bit proto_ok);
        int n;
        proto_ok = 1'b1;
        lat = 0;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) proto_ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.bcd_in   = bcd;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.bcd_in   = 16'($urandom);
        while (!bus.out_valid && lat < 20) begin
            if (bus.in_ready) proto_ok = 1'b0;
            if (noise) begin
                bus.in_valid  = 1'($urandom);
                bus.bcd_in    = 16'($urandom);
                bus.out_ready = 1'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        res   = longint'(bus.bin_out);
        err_o = cur_err();
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!bus.out_valid || longint'(bus.bin_out) != res || bus.in_ready || cur_err() != err_o)
                proto_ok = 1'b0;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        if (bus.out_valid || !bus.in_ready || longint'(bus.bin_out) != res || cur_err())
            proto_ok = 1'b0;
    endtask

    task automatic run_conv8(input logic [11:0] bcd, output longint res, output int lat);
        int n;
        n = 0;
        lat = 0;
        while (!bus8.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        bus8.in_valid = 1'b1;
        bus8.bcd_in   = bcd;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        while (!bus8.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        res = longint'(bus8.bin_out);
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        bus8.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        longint res;
        bit     err_o;
        bit     exp_err;
        int     lat;
        bit     ok;
        longint exp_v;
        logic [15:0] bcd;
        logic [11:0] bcd8;

        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.bcd_in     = '0;
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b0;
        bus8.bcd_in    = '0;

        vecs.push_back('{16'h2456, 0, 2456, 1'b0});
        vecs.push_back('{16'h0000, 1, 0, 1'b0});
        vecs.push_back('{16'h9999, 0, 9999, 1'b0});
        vecs.push_back('{16'h0059, 10, 59, 1'b0});
        vecs.push_back('{16'h0123, 0, 123, 1'b0});
`ifdef BCD2BIN_DIGIT_CHECK_EN
        vecs.push_back('{16'h1A00, 2, 0, 1'b1});
`else
        vecs.push_back('{16'h1A00, 2, 2000, 1'b0});
`endif
        vecs.push_back('{16'h1000, 3, 1000, 1'b0});
        vecs.push_back('{16'h0909, 0, 909, 1'b0});

        // Reset state
        #1;
        check("reset_in_ready", 64'(bus.in_ready), 64'd0);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_bin_out", 64'(bus.bin_out), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_in_ready", 64'(bus.in_ready), 64'd1);

        // Directed table
        foreach (vecs[i]) begin
            run_conv(vecs[i].bcd, vecs[i].hold, 1'b0, res, err_o, lat, ok);
            check($sformatf("vec%0d_value", i), 64'(res), 64'(vecs[i].exp_val));
            check($sformatf("vec%0d_err", i), 64'(err_o), 64'(vecs[i].exp_err));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
            check($sformatf("vec%0d_handshake", i), 64'(ok), 64'd1);
        end

        // Asynchronous reset two cycles into CONV
        bus.in_valid = 1'b1;
        bus.bcd_in   = 16'h1234;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        check("pre_reset_bin_out_held", 64'(bus.bin_out), 64'd909);
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 64'(bus.out_valid), 64'd0);
        check("midreset_bin_out", 64'(bus.bin_out), 64'd0);
        check("midreset_in_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_conv(16'h0007, 0, 1'b0, res, err_o, lat, ok);
        check("post_reset_value", 64'(res), 64'd7);
        check("post_reset_latency", 64'(lat), 64'd4);
        check("post_reset_handshake", 64'(ok), 64'd1);

        // Randomized conversions against the positional model
        for (int t = 0; t < 40; t++) begin
            for (int d = 0; d < 4; d++) begin
                if ($urandom_range(0, 7) == 0) bcd[4*d +: 4] = 4'($urandom);
                else                           bcd[4*d +: 4] = 4'($urandom_range(0, 9));
            end
            exp_v = model({16'h0, bcd}, 4, 14, exp_err);
            run_conv(bcd, int'($urandom_range(0, 3)), 1'b1, res, err_o, lat, ok);
            check($sformatf("rand%0d_value_%h", t, bcd), 64'(res), 64'(exp_v));
            check($sformatf("rand%0d_err", t), 64'(err_o), 64'(exp_err));
            check($sformatf("rand%0d_latency", t), 64'(lat), 64'd4);
            check($sformatf("rand%0d_handshake", t), 64'(ok), 64'd1);
        end

        // Narrow instance: 3 digits, 8-bit result wraps
        run_conv8(12'h300, res, lat);
        check("wrap8_300", 64'(res), 64'd44);
        check("wrap8_latency", 64'(lat), 64'd3);
        run_conv8(12'h999, res, lat);
        check("wrap8_999", 64'(res), 64'd231);
        for (int t = 0; t < 20; t++) begin
            for (int d = 0; d < 3; d++) bcd8[4*d +: 4] = 4'($urandom_range(0, 9));
            exp_v = model({20'h0, bcd8}, 3, 8, exp_err);
            run_conv8(bcd8, res, lat);
            check($sformatf("rand8_%0d_value_%h", t, bcd8), 64'(res), 64'(exp_v));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
